// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - state codes, loop-mode and dither constants, output decode for the PLL power-up sequencer
package pll_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_DISABLE = 4'd1,
    ST_LOAD    = 4'd2,
    ST_RST1    = 4'd3,
    ST_RELEASE = 4'd4,
    ST_ENABLE  = 4'd5,
    ST_RST2    = 4'd6,
    ST_SETTLE  = 4'd7,
    ST_CAL_ON  = 4'd8,
    ST_CAL_OFF = 4'd9,
    ST_RUN     = 4'd10,
    ST_ERR     = 4'd11
  } state_t;

  localparam logic MODE_PFDCP = 1'b0;
  localparam logic MODE_SPDGM = 1'b1;

  localparam logic [1:0] DN_S_PFDCP = 2'b00;
  localparam logic [1:0] DN_S_SPDGM = 2'b10;

  localparam int LOCK_CNT     = 8;
  localparam int LOCK_TO_MULT = 16;

  typedef struct packed {
    logic       narst;
    logic       ctrl;
    logic       pll_en;
    logic       dtc_en;
    logic       mmd_en;
    logic       dsm_en;
    logic       pfd_en;
    logic       cp_en;
    logic       spd_en;
    logic       phesig_en;
    logic       gaincal_en;
    logic       cal_mode;
    logic [1:0] dn_s;
    logic       otwcali_en;
    logic       busy;
    logic       done;
    logic       err;
  } seq_out_t;

  // Moore output map; paths stay off until LOAD so the loop never sees a half-configured frac path
  function automatic seq_out_t seq_decode(input state_t st, input logic mode);
    seq_out_t o;
    o       = '0;
    o.narst = 1'b1;
    o.ctrl  = 1'b1;
    o.dn_s  = DN_S_PFDCP;
    if (st != ST_IDLE && st != ST_DISABLE) begin
      o.dtc_en = 1'b1;
      o.mmd_en = 1'b1;
      o.dsm_en = 1'b1;
      if (mode == MODE_SPDGM) begin
        o.spd_en     = 1'b1;
        o.phesig_en  = 1'b1;
        o.gaincal_en = 1'b1;
        o.cal_mode   = 1'b1;
        o.dn_s       = DN_S_SPDGM;
      end else begin
        o.pfd_en = 1'b1;
        o.cp_en  = 1'b1;
      end
    end
    o.narst      = !(st inside {ST_RST1, ST_RST2});
    o.ctrl       = !(st inside {ST_RELEASE, ST_ENABLE, ST_RST2, ST_SETTLE,
                                ST_CAL_ON, ST_CAL_OFF, ST_RUN, ST_ERR});
    o.pll_en     = st inside {ST_ENABLE, ST_RST2, ST_SETTLE, ST_CAL_ON,
                              ST_CAL_OFF, ST_RUN, ST_ERR};
    o.otwcali_en = st inside {ST_CAL_ON, ST_RUN};
    o.busy       = !(st inside {ST_IDLE, ST_RUN, ST_ERR});
    o.done       = (st == ST_RUN);
    o.err        = (st == ST_ERR);
    return o;
  endfunction

endpackage

// File: rtl/pll_seq_timer.sv
// rtl/pll_seq_timer.sv - CW-bit loadable down-counter that saturates at zero and flags it
module pll_seq_timer #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] count,
  output logic          zero
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign count = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/pll_pwrup_seq.sv
// rtl/pll_pwrup_seq.sv - PLL power-up/config sequencer; PLL_SEQ_LOCKWAIT_EN adds lock-qualified settle exit and ERR state
module pll_pwrup_seq
  import pll_seq_pkg::*;
#(
  parameter int T_RST    = 2,
  parameter int T_SETTLE = 100,
  parameter int T_CALON  = 1300,
  parameter int T_CALOFF = 1000,
  parameter int CW       = 16
) (
  input  logic       CLK,
  input  logic       NRST,
  input  logic       START,
  input  logic       ABORT,
  input  logic       MODE,
  input  logic       LOCK,
  output logic       NARST_O,
  output logic       CTRL_O,
  output logic       PLL_EN_O,
  output logic       DTC_EN_O,
  output logic       MMD_EN_O,
  output logic       DSM_EN_O,
  output logic       PFD_EN_O,
  output logic       CP_EN_O,
  output logic       SPD_EN_O,
  output logic       PHESIG_GEN_EN_O,
  output logic       DTC_GAINCAL_EN_O,
  output logic       CAL_MODE_O,
  output logic [1:0] DN_S_O,
  output logic       OTWCALI_EN_O,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic [3:0] STATE_O
);

  localparam int RST_N    = (T_RST    < 1) ? 1 : T_RST;
  localparam int SETTLE_N = (T_SETTLE < 1) ? 1 : T_SETTLE;
  localparam int CALON_N  = (T_CALON  < 1) ? 1 : T_CALON;
  localparam int CALOFF_N = (T_CALOFF < 1) ? 1 : T_CALOFF;

  localparam logic [CW-1:0] RST_M1    = CW'(RST_N - 1);
  localparam logic [CW-1:0] SETTLE_M1 = CW'(SETTLE_N - 1);
  localparam logic [CW-1:0] CALON_M1  = CW'(CALON_N - 1);
  localparam logic [CW-1:0] CALOFF_M1 = CW'(CALOFF_N - 1);

  state_t        state_q, state_d;
  logic          mode_q;
  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic [CW-1:0] tmr_cnt;
  logic          tmr_zero;
  seq_out_t      out_q, out_d;
  logic [3:0]    st_q;

  pll_seq_timer #(.CW(CW)) u_timer (
    .clk      (CLK),
    .nrst     (NRST),
    .load     (tmr_load),
    .load_val (tmr_val),
    .count    (tmr_cnt),
    .zero     (tmr_zero)
  );

`ifdef PLL_SEQ_LOCKWAIT_EN
  localparam int            TMAX     = (1 << CW) - 1;
  localparam int            TO_N     = LOCK_TO_MULT * SETTLE_N;
  localparam logic [CW-1:0] TO_M1    = CW'(((TO_N - 1) > TMAX) ? TMAX : (TO_N - 1));
  // The timer counts the whole timeout window; at or below GATE the minimum settle time has passed
  localparam logic [CW-1:0] GATE     = TO_M1 - SETTLE_M1;
  localparam logic [2:0]    LOCK_MAX = 3'(LOCK_CNT - 1);

  logic [2:0] lock_cnt;
  logic       lock_ok;

  always_ff @(posedge CLK) begin
    if (!NRST || state_q != ST_SETTLE || !LOCK) begin
      lock_cnt <= '0;
    end else if (lock_cnt != LOCK_MAX) begin
      lock_cnt <= lock_cnt + 3'd1;
    end
  end

  assign lock_ok = LOCK && (lock_cnt == LOCK_MAX) && (tmr_cnt <= GATE);
  assign ERR     = out_q.err;
`else
  localparam logic [CW-1:0] TO_M1 = SETTLE_M1;

  logic unused_sig;
  assign unused_sig = ^{LOCK, tmr_cnt, out_q.err};
  assign ERR        = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    out_d    = seq_decode(state_q, mode_q);
    case (state_q)
      ST_IDLE:    if (START) state_d = ST_DISABLE;
      ST_DISABLE: state_d = ST_LOAD;
      ST_LOAD:    state_d = ST_RST1;
      ST_RST1:    if (tmr_zero) state_d = ST_RELEASE;
      ST_RELEASE: state_d = ST_ENABLE;
      ST_ENABLE:  state_d = ST_RST2;
      ST_RST2:    if (tmr_zero) state_d = ST_SETTLE;
`ifdef PLL_SEQ_LOCKWAIT_EN
      ST_SETTLE: begin
        if (lock_ok) begin
          state_d = ST_CAL_ON;
        end else if (tmr_zero) begin
          state_d = ST_ERR;
        end
      end
      ST_ERR:     state_d = ST_ERR;
`else
      ST_SETTLE:  if (tmr_zero) state_d = ST_CAL_ON;
`endif
      ST_CAL_ON:  if (tmr_zero) state_d = ST_CAL_OFF;
      ST_CAL_OFF: if (tmr_zero) state_d = ST_RUN;
      ST_RUN:     state_d = ST_RUN;
      default:    state_d = ST_IDLE;
    endcase
    if (ABORT) begin
      state_d = ST_IDLE;
    end
    if (state_d != state_q) begin
      tmr_load = 1'b1;
      case (state_d)
        ST_RST1, ST_RST2: tmr_val = RST_M1;
        ST_SETTLE:        tmr_val = TO_M1;
        ST_CAL_ON:        tmr_val = CALON_M1;
        ST_CAL_OFF:       tmr_val = CALOFF_M1;
        default:          tmr_val = '0;
      endcase
    end
  end

  // MODE tracks the pin while idle and freezes on the cycle START is accepted
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_PFDCP;
      out_q   <= seq_decode(ST_IDLE, MODE_PFDCP);
      st_q    <= ST_IDLE;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE) begin
        mode_q <= MODE;
      end
      out_q   <= out_d;
      st_q    <= state_q;
    end
  end

  assign NARST_O          = out_q.narst;
  assign CTRL_O           = out_q.ctrl;
  assign PLL_EN_O         = out_q.pll_en;
  assign DTC_EN_O         = out_q.dtc_en;
  assign MMD_EN_O         = out_q.mmd_en;
  assign DSM_EN_O         = out_q.dsm_en;
  assign PFD_EN_O         = out_q.pfd_en;
  assign CP_EN_O          = out_q.cp_en;
  assign SPD_EN_O         = out_q.spd_en;
  assign PHESIG_GEN_EN_O  = out_q.phesig_en;
  assign DTC_GAINCAL_EN_O = out_q.gaincal_en;
  assign CAL_MODE_O       = out_q.cal_mode;
  assign DN_S_O           = out_q.dn_s;
  assign OTWCALI_EN_O     = out_q.otwcali_en;
  assign BUSY             = out_q.busy;
  assign DONE             = out_q.done;
  assign STATE_O          = st_q;

endmodule

// File: tb/tb_pll_pwrup_seq.sv
// tb/tb_pll_pwrup_seq.sv - self-checking bench for pll_pwrup_seq (default and small-timing instances)
module tb_pll_pwrup_seq;
  import pll_seq_pkg::*;

`ifdef PLL_SEQ_LOCKWAIT_EN
  localparam bit LOCKWAIT  = 1'b1;
  localparam int SMALL_SET = 8;
`else
  localparam bit LOCKWAIT  = 1'b0;
  localparam int SMALL_SET = 1;
`endif
  localparam int NTBL = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nrst_a, start_a, abort_a, mode_a, lock_a;
  logic nrst_b, start_b, abort_b, mode_b, lock_b;
  wire [21:0] v_a;
  wire [21:0] v_b;

  int checks   = 0;
  int failures = 0;

  pll_pwrup_seq u_dut (
    .CLK(clk), .NRST(nrst_a), .START(start_a), .ABORT(abort_a), .MODE(mode_a), .LOCK(lock_a),
    .NARST_O(v_a[21]), .CTRL_O(v_a[20]), .PLL_EN_O(v_a[19]), .DTC_EN_O(v_a[18]),
    .MMD_EN_O(v_a[17]), .DSM_EN_O(v_a[16]), .PFD_EN_O(v_a[15]), .CP_EN_O(v_a[14]),
    .SPD_EN_O(v_a[13]), .PHESIG_GEN_EN_O(v_a[12]), .DTC_GAINCAL_EN_O(v_a[11]),
    .CAL_MODE_O(v_a[10]), .DN_S_O(v_a[9:8]), .OTWCALI_EN_O(v_a[7]), .BUSY(v_a[6]),
    .DONE(v_a[5]), .ERR(v_a[4]), .STATE_O(v_a[3:0])
  );

  pll_pwrup_seq #(.T_RST(0), .T_SETTLE(1), .T_CALON(3), .T_CALOFF(2)) u_small (
    .CLK(clk), .NRST(nrst_b), .START(start_b), .ABORT(abort_b), .MODE(mode_b), .LOCK(lock_b),
    .NARST_O(v_b[21]), .CTRL_O(v_b[20]), .PLL_EN_O(v_b[19]), .DTC_EN_O(v_b[18]),
    .MMD_EN_O(v_b[17]), .DSM_EN_O(v_b[16]), .PFD_EN_O(v_b[15]), .CP_EN_O(v_b[14]),
    .SPD_EN_O(v_b[13]), .PHESIG_GEN_EN_O(v_b[12]), .DTC_GAINCAL_EN_O(v_b[11]),
    .CAL_MODE_O(v_b[10]), .DN_S_O(v_b[9:8]), .OTWCALI_EN_O(v_b[7]), .BUSY(v_b[6]),
    .DONE(v_b[5]), .ERR(v_b[4]), .STATE_O(v_b[3:0])
  );

  typedef struct {
    int   off;
    logic narst, ctrl, pll_en, otw, busy, done;
  } vec_t;
  vec_t tbl [NTBL];

  // Expected output vector n cycles after the START edge, from the phase schedule alone
  function automatic logic [21:0] model(input int n, input bit md, input int trst,
                                        input int tset, input int ton, input int toff);
    int         d [10];
    logic [3:0] code [10];
    int         p, t;
    logic       pa, pm, pp;
    if (n < 1) return {2'b11, 16'b0, 4'(ST_IDLE)};
    d    = '{1, 1, trst, 1, 1, trst, tset, ton, toff, 1 << 30};
    code = '{ST_DISABLE, ST_LOAD, ST_RST1, ST_RELEASE, ST_ENABLE, ST_RST2,
             ST_SETTLE, ST_CAL_ON, ST_CAL_OFF, ST_RUN};
    p = 0;
    t = n - 1;
    while (t >= d[p]) begin
      t -= d[p];
      p++;
    end
    pa = (p >= 1);
    pm = pa & md;
    pp = pa & ~md;
    return {(p != 2) && (p != 5), p < 3, p >= 4, pa, pa, pa, pp, pp, pm, pm, pm, pm,
            pm ? 2'b10 : 2'b00, (p == 7) || (p == 9), p < 9, p == 9, 1'b0, code[p]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_main(input bit md, input int last, input int abort_at);
    mode_a  = md;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    mode_a  = ~md;
    for (int n = 1; n <= last; n++) begin
      start_a = (n == 50) || (n == 2412);
      abort_a = (n == abort_at);
      lock_a  = LOCKWAIT ? 1'b1 : 1'($urandom_range(0, 1));
      tick();
      chk($sformatf("main_m%0d_n%0d", md, n), v_a, model(n, md, 2, 100, 1300, 1000));
      if (n == 10) chk($sformatf("paths_m%0d", md), v_a[15:8], md ? 8'b00111110 : 8'b11000000);
      for (int i = 0; i < NTBL; i++) begin
        if (tbl[i].off == n)
          chk($sformatf("tbl_m%0d_off%0d", md, n), {v_a[21], v_a[20], v_a[19], v_a[7], v_a[6], v_a[5]},
              {tbl[i].narst, tbl[i].ctrl, tbl[i].pll_en, tbl[i].otw, tbl[i].busy, tbl[i].done});
      end
    end
    start_a = 1'b0;
    abort_a = 1'b0;
  endtask

  task automatic abort_main(input string nm);
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    tick();
    chk(nm, v_a, model(0, 1'b0, 1, 1, 1, 1));
  endtask

  initial begin
    int   idle_n, ab;
    bit   md;
    logic [21:0] e;
    tbl = '{'{1, 1, 1, 0, 0, 1, 0}, '{2, 1, 1, 0, 0, 1, 0}, '{3, 0, 1, 0, 0, 1, 0},
            '{4, 0, 1, 0, 0, 1, 0}, '{5, 1, 0, 0, 0, 1, 0}, '{6, 1, 0, 1, 0, 1, 0},
            '{7, 0, 0, 1, 0, 1, 0}, '{8, 0, 0, 1, 0, 1, 0}, '{9, 1, 0, 1, 0, 1, 0},
            '{108, 1, 0, 1, 0, 1, 0}, '{109, 1, 0, 1, 1, 1, 0}, '{1408, 1, 0, 1, 1, 1, 0},
            '{1409, 1, 0, 1, 0, 1, 0}, '{2408, 1, 0, 1, 0, 1, 0}, '{2409, 1, 0, 1, 1, 0, 1}};
    nrst_a = 0; start_a = 0; abort_a = 0; mode_a = 0; lock_a = 0;
    nrst_b = 0; start_b = 0; abort_b = 0; mode_b = 0; lock_b = 0;
    @(negedge clk);
    repeat (5) tick();
    chk("reset_a", v_a, model(0, 1'b0, 1, 1, 1, 1));
    chk("reset_b", v_b, model(0, 1'b0, 1, 1, 1, 1));
    nrst_a = 1;
    nrst_b = 1;
    repeat (3) tick();
    chk("idle_a", v_a, model(0, 1'b0, 1, 1, 1, 1));

    run_main(1'b0, 2415, 0);
    abort_main("abort_run_m0");
    run_main(1'b1, 2415, 0);
    abort_main("abort_run_m1");
    run_main(1'b1, 500, 500);
    tick();
    chk("abort_cal_on", v_a, model(0, 1'b0, 1, 1, 1, 1));
    chk("abort_otw", v_a[7], 32'd0);

`ifdef PLL_SEQ_LOCKWAIT_EN
    mode_a = 1'b0; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int n = 1; n <= 170; n++) begin
      lock_a = (n >= 159);
      tick();
      chk($sformatf("lock_n%0d", n), v_a, model(n, 1'b0, 2, 158, 1300, 1000));
    end
    abort_main("abort_after_lock");
    mode_a = 1'b1; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int n = 1; n <= 1612; n++) begin
      lock_a  = (n >= 300) && (n < 307);
      start_a = (n == 1610);
      tick();
      e = model(n > 1608 ? 1608 : n, 1'b1, 2, 1600, 1300, 1000);
      if (n > 1608) begin
        e[6]   = 1'b0;
        e[4]   = 1'b1;
        e[3:0] = ST_ERR;
      end
      if (n >= 1600) chk($sformatf("lock_to_n%0d", n), v_a, e);
    end
    start_a = 1'b0;
    abort_main("abort_err");
`endif

    mode_b = 1'b1; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      tick();
      chk($sformatf("small_n%0d", n), v_b, model(n, 1'b1, 1, SMALL_SET, 3, 2));
    end
    nrst_b = 1'b0;
    tick();
    chk("nrst_in_rst2", v_b, model(0, 1'b0, 1, 1, 1, 1));
    nrst_b = 1'b1;
    tick();
    chk("idle_after_nrst", v_b, model(0, 1'b0, 1, 1, 1, 1));

    for (int it = 0; it < 30; it++) begin
      idle_n = $urandom_range(0, 3);
      md     = 1'($urandom_range(0, 1));
      ab     = $urandom_range(1, 24);
      for (int j = 0; j < idle_n; j++) begin
        lock_b = LOCKWAIT ? 1'b1 : 1'($urandom_range(0, 1));
        tick();
        chk($sformatf("rnd%0d_idle", it), v_b, model(0, 1'b0, 1, 1, 1, 1));
      end
      mode_b = md; start_b = 1'b1;
      tick();
      for (int n = 1; n <= ab; n++) begin
        mode_b  = 1'($urandom_range(0, 1));
        start_b = 1'($urandom_range(0, 1));
        abort_b = (n == ab);
        lock_b  = LOCKWAIT ? 1'b1 : 1'($urandom_range(0, 1));
        tick();
        chk($sformatf("rnd%0d_n%0d", it, n), v_b, model(n, md, 1, SMALL_SET, 3, 2));
      end
      abort_b = 1'b0;
      start_b = 1'b0;
      tick();
      chk($sformatf("rnd%0d_abort", it), v_b, model(0, 1'b0, 1, 1, 1, 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
